// File: rtl/pwm_gen_pkg.sv
// Shared definitions for the PWM generator: FSM state encoding and default width.
package pwm_gen_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter: each output rises DEAD cycles after the raw level settles
// on its side and drops as soon as the raw level leaves it.
module pwm_deadtime #(
  parameter int DEAD = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic en_i,
  output logic pwm_o,
  output logic pwm_n_o
);

  localparam int CW = $clog2(DEAD + 1);
  localparam logic [CW-1:0] LOAD = CW'(DEAD - 1);

  logic          lvl_q;
  logic [CW-1:0] cnt_q;
  logic          settled;

  // Any raw edge (or disable) restarts the dead-time window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lvl_q <= 1'b0;
      cnt_q <= LOAD;
    end else if (!en_i || (raw_i != lvl_q)) begin
      lvl_q <= raw_i;
      cnt_q <= LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign settled = en_i && (raw_i == lvl_q) && (cnt_q == '0);
  assign pwm_o   = settled && raw_i;
  assign pwm_n_o = settled && !raw_i;

endmodule

// File: rtl/pwm_gen.sv
// PWM generator driven by an external free-running count; duty updates land on
// period wraps only. Optional dead-time insertion under PWM_DEADTIME_EN.
//
// state | meaning
// IDLE  | outputs low, waiting for en
// ARM   | enabled, waiting for the first wrap to start a clean period
// RUN   | pwm = cnt < duty_act
module pwm_gen
  import pwm_gen_pkg::*;
#(
  parameter int W = W_DEF,
`ifdef PWM_DEADTIME_EN
  parameter int DEAD = 2,
`endif
  parameter logic [W-1:0] DUTY_RST = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] cnt_in_i,
  input  logic         en_i,
  input  logic [W-1:0] duty_in_i,
  input  logic         duty_valid_i,
  output logic         duty_ready_o,
  output logic         pwm_o,
  output logic         pwm_n_o,
  output logic         wrap_pulse_o,
  output logic         running_o
);

  state_e       state_q, state_d;
  logic [W-1:0] cnt_prev_q;
  logic [W-1:0] duty_act_q, duty_act_d;
  logic [W-1:0] duty_pend_q, duty_pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         wrap_q;
  logic         pwm_q, pwm_d;
  logic         wrap, xfer, apply;

  // A backwards step (including an upstream counter reset) is a period boundary.
  assign wrap  = cnt_in_i < cnt_prev_q;
  assign xfer  = duty_valid_i && !pend_vld_q;
  assign apply = wrap && pend_vld_q && (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en_i) state_d = ST_ARM;
      ST_ARM: begin
        if (!en_i)     state_d = ST_IDLE;
        else if (wrap) state_d = ST_RUN;
      end
      ST_RUN:  if (!en_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // apply and xfer are mutually exclusive: a transfer needs an empty pending slot.
  always_comb begin
    duty_act_d  = duty_act_q;
    duty_pend_d = duty_pend_q;
    pend_vld_d  = pend_vld_q;
    if (apply) begin
      duty_act_d = duty_pend_q;
      pend_vld_d = 1'b0;
    end else if (xfer) begin
      duty_pend_d = duty_in_i;
      pend_vld_d  = 1'b1;
    end
    pwm_d = (state_d == ST_RUN) && (cnt_in_i < duty_act_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_prev_q  <= '0;
      duty_act_q  <= DUTY_RST;
      duty_pend_q <= '0;
      pend_vld_q  <= 1'b0;
      wrap_q      <= 1'b0;
      pwm_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_prev_q  <= cnt_in_i;
      duty_act_q  <= duty_act_d;
      duty_pend_q <= duty_pend_d;
      pend_vld_q  <= pend_vld_d;
      wrap_q      <= wrap;
      pwm_q       <= pwm_d;
    end
  end

  assign duty_ready_o = !pend_vld_q;
  assign wrap_pulse_o = wrap_q;
  assign running_o    = (state_q == ST_RUN);

`ifdef PWM_DEADTIME_EN
  pwm_deadtime #(
    .DEAD(DEAD)
  ) u_deadtime (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raw_i  (pwm_q),
    .en_i   (running_o),
    .pwm_o  (pwm_o),
    .pwm_n_o(pwm_n_o)
  );
`else
  assign pwm_o   = pwm_q;
  assign pwm_n_o = running_o && !pwm_q;
`endif

endmodule
